sev_seg_capture: RTL and testbench
==================================

Name: sev_seg_capture

Overview:
- Receive-side counterpart of sev_seg_controller: samples the multiplexed anode/segment pins and reconstructs the 8 displayed hex digits.
- Used in FPGA loopback tests and simulation benches to check lock-state display output without reading board LEDs.
- Synchronises the pins, rejects ghosting during digit switchover, decodes segment patterns, and reports complete frames, illegal patterns and loss of scanning.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser on AN and Seg (≥2).
- STABLE_CYCLES, 4, consecutive cycles the synchronised {AN,Seg} must be unchanged before a capture (≥1).
- TIMEOUT_CYCLES, 1000000, cycles without any capture before display_lost asserts.

Ports:
- clk, input, 1, system clock (100 MHz on board).
- rst, input, 1, asynchronous active-high reset.
- AN, input, 8, anode enables, active-low; bit i selects digit i.
- Seg, input, 7, segments {g,f,e,d,c,b,a}, active-low.
- clear_err, input, 1, synchronous pulse that clears err_pattern.
- digits, output, 32, decoded digit i at [4i+3:4i].
- blank, output, 8, bit i=1 when digit i was last captured with all segments off.
- seen, output, 8, digits captured since the last frame_done.
- frame_done, output, 1, one-cycle pulse when all 8 digits have been captured.
- err_pattern, output, 1, sticky; an unrecognised segment pattern was captured.
- err_digit, output, 3, index of the first bad digit since the last clear.
- display_lost, output, 1, no capture for TIMEOUT_CYCLES.

Behaviour:
- Reset (asynchronous, any time): digits=0, blank=8'hFF, seen=0, frame_done=0, err_pattern=0, err_digit=0, display_lost=0, synchroniser flops=all 1s, stable counter=0, timeout counter=0.
- Synchroniser: each AN and Seg bit passes through SYNC_STAGES flops. All logic below uses the synchronised values (sAN, sSeg).
- Stability counter: resets to 0 in any cycle where {sAN,sSeg} differs from the previous cycle. Otherwise it increments, saturating at STABLE_CYCLES.
- Capture: occurs in the cycle the counter steps from STABLE_CYCLES-1 to STABLE_CYCLES, only if ~sAN is one-hot. Exactly one capture per stable window. All-high or multi-low AN never captures.
- Latency: pins change and then hold. Outputs update at clock edge SYNC_STAGES+STABLE_CYCLES+1 after the pin change (7 with defaults).
- Decode of ~sSeg (active-high gfedcba):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - 00 → blank.
- On capture of digit i:
  - Legal hex pattern: digits[i]=value, blank[i]=0.
  - Blank pattern: digits[i] holds, blank[i]=1.
  - Any other pattern: digits[i] and blank[i] hold. err_pattern=1; err_digit=i, but only if err_pattern was 0.
  - In all three cases: seen[i]=1, timeout counter cleared, display_lost=0.
- Frame:
  - If a capture makes seen==8'hFF, frame_done pulses on the same edge the digit updates, and seen clears to 0 on the next edge.
  - Recapturing an already-seen digit does not re-pulse frame_done.
- clear_err: clears err_pattern on the next edge. If a bad capture lands in the same cycle, the error wins: err_pattern=1, err_digit=that index.
- Timeout: the counter increments each cycle without a capture, saturating at TIMEOUT_CYCLES. display_lost=1 while it is saturated. Holds all other outputs.
- Reset mid-window: all state is abandoned. After rst deasserts, the synchroniser refills before any capture (full latency applies again).

Test Plan:
- Assert rst mid-run → every output at its reset value within the same cycle, asynchronously. Release and drive AN=8'hFE, Seg=~7'h5B → digits[3:0]=2, seen=8'h01 exactly 7 edges after stimulus.
- Switch AN=8'hFD with Seg=~7'h06 for 3 cycles (glitch), then Seg=~7'h4F held → digits[7:4]=3, never 1.
- Scan digits 0..7 with values 0..7, each held 10 cycles → frame_done pulses once on the digit-7 update; seen returns to 0 next cycle.
- Digit 5 with Seg=~7'h01 → err_pattern=1, err_digit=5. A later bad digit 2 leaves err_digit=5. clear_err → 0.
- AN=8'hFC (two low) held 20 cycles → no capture, seen unchanged.
- Freeze AN=8'hFF for TIMEOUT_CYCLES (set to 50) → display_lost=1 at cycle 50. Next valid capture → display_lost=0, digits updated.

Source files
------------

// File: rtl/sev_seg_capture.sv
// ---------------------------------------------------------------------------
// sev_seg_capture
//
// Receive side of a multiplexed 8-digit seven-segment display. It samples the
// anode and segment pins, waits for each digit slot to settle, decodes the
// hex glyph, and rebuilds the 8 displayed digits. It also reports complete
// frames, illegal glyphs, and loss of scanning.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   AN[7:0]      anode enables, active-low, bit i selects digit i
//   Seg[6:0]     segments {g,f,e,d,c,b,a}, active-low
//   clear_err    single-cycle pulse that clears err_pattern
//   digits[31:0] decoded digit i at [4i+3:4i]
//   blank[7:0]   digit i was last captured with every segment off
//   seen[7:0]    digits captured since the last frame_done
//   frame_done   one-cycle pulse when all 8 digits have been captured
//   err_pattern  sticky flag: an unrecognised glyph was captured
//   err_digit    index of the first bad digit since the last clear
//   display_lost no capture for TIMEOUT_CYCLES cycles
// ---------------------------------------------------------------------------
module sev_seg_capture #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  AN,
    input  logic [6:0]  Seg,
    input  logic        clear_err,
    output logic [31:0] digits,
    output logic [7:0]  blank,
    output logic [7:0]  seen,
    output logic        frame_done,
    output logic        err_pattern,
    output logic [2:0]  err_digit,
    output logic        display_lost
);

    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SCW-1:0] STABLE_MAX  = SCW'(STABLE_CYCLES);
    localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_CYCLES - 1);
    localparam logic [TOW-1:0] TIMEOUT_MAX = TOW'(TIMEOUT_CYCLES);

    // Synchroniser chain on {AN,Seg}; element 0 is the raw pin value.
    logic [SYNC_STAGES:0][14:0] w_chain;
    assign w_chain[0] = {AN, Seg};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [14:0] r_stage;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_stage <= '1;
                else     r_stage <= w_chain[gi];
            end
            assign w_chain[gi+1] = r_stage;
        end
    endgenerate

    logic [14:0] w_sync;
    logic [7:0]  w_san;
    logic [6:0]  w_sseg;
    assign w_sync = w_chain[SYNC_STAGES];
    assign w_san  = w_sync[14:7];
    assign w_sseg = w_sync[6:0];

    // Stability tracking: the window restarts whenever the synchronised
    // pins move, which filters ghosting while the scanner switches digits.
    logic [14:0]    r_prev;
    logic [SCW-1:0] r_stab_cnt;
    logic           w_same;
    assign w_same = (w_sync == r_prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev     <= '1;
            r_stab_cnt <= '0;
        end else begin
            r_prev <= w_sync;
            if (!w_same)
                r_stab_cnt <= '0;
            else if (r_stab_cnt != STABLE_MAX)
                r_stab_cnt <= r_stab_cnt + 1'b1;
        end
    end

    // Capture fires once, on the step into saturation, and only when
    // exactly one anode is driven.
    logic [7:0] w_sel;
    logic       w_one_hot;
    logic       w_capture;
    assign w_sel     = ~w_san;
    assign w_one_hot = (w_sel != 8'h00) && ((w_sel & (w_sel - 8'd1)) == 8'h00);
    assign w_capture = w_same && (r_stab_cnt == STABLE_LAST) && w_one_hot;

    logic [2:0] w_idx;
    always_comb begin
        w_idx = '0;
        for (int k = 0; k < 8; k++)
            if (w_sel[k]) w_idx = 3'(k);
    end

    // Glyph decode on active-high segments.
    logic [6:0] w_seg_on;
    logic [3:0] w_hex_val;
    logic       w_legal;
    logic       w_blank_pat;
    assign w_seg_on    = ~w_sseg;
    assign w_blank_pat = (w_seg_on == 7'h00);

    always_comb begin
        w_hex_val = 4'h0;
        w_legal   = 1'b1;
        case (w_seg_on)
            7'h3F: w_hex_val = 4'h0;
            7'h06: w_hex_val = 4'h1;
            7'h5B: w_hex_val = 4'h2;
            7'h4F: w_hex_val = 4'h3;
            7'h66: w_hex_val = 4'h4;
            7'h6D: w_hex_val = 4'h5;
            7'h7D: w_hex_val = 4'h6;
            7'h07: w_hex_val = 4'h7;
            7'h7F: w_hex_val = 4'h8;
            7'h6F: w_hex_val = 4'h9;
            7'h77: w_hex_val = 4'hA;
            7'h7C: w_hex_val = 4'hB;
            7'h39: w_hex_val = 4'hC;
            7'h5E: w_hex_val = 4'hD;
            7'h79: w_hex_val = 4'hE;
            7'h71: w_hex_val = 4'hF;
            default: w_legal = 1'b0;
        endcase
    end

    logic w_bad;
    assign w_bad = w_capture && !w_legal && !w_blank_pat;

    // Per-digit value and blank flags.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            logic [3:0] r_digit;
            logic       r_blank;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_digit <= 4'h0;
                    r_blank <= 1'b1;
                end else if (w_capture && w_sel[gi]) begin
                    if (w_legal) begin
                        r_digit <= w_hex_val;
                        r_blank <= 1'b0;
                    end else if (w_blank_pat) begin
                        r_blank <= 1'b1;
                    end
                end
            end
            assign digits[4*gi +: 4] = r_digit;
            assign blank[gi]         = r_blank;
        end
    endgenerate

    // Frame tracking: seen sits at all-ones for exactly the frame_done cycle
    // and is cleared on the following edge.
    logic [7:0] r_seen;
    logic       r_frame_done;
    logic [7:0] w_seen_or;
    logic       w_frame;
    assign w_seen_or = r_seen | (w_capture ? w_sel : 8'h00);
    assign w_frame   = w_capture && (w_seen_or == 8'hFF) && (r_seen != 8'hFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seen       <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame;
            if (r_frame_done)
                r_seen <= w_capture ? w_sel : 8'h00;
            else
                r_seen <= w_seen_or;
        end
    end

    // Error flag: a bad capture outranks a simultaneous clear, and the
    // index only latches when the flag is (or is being) cleared.
    logic       r_err_pattern;
    logic [2:0] r_err_digit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_pattern <= 1'b0;
            r_err_digit   <= 3'd0;
        end else if (w_bad) begin
            r_err_pattern <= 1'b1;
            if (!r_err_pattern || clear_err)
                r_err_digit <= w_idx;
        end else if (clear_err) begin
            r_err_pattern <= 1'b0;
        end
    end

    // Scan-loss watchdog.
    logic [TOW-1:0] r_to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_to_cnt <= '0;
        else if (w_capture)
            r_to_cnt <= '0;
        else if (r_to_cnt != TIMEOUT_MAX)
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign seen         = r_seen;
    assign frame_done   = r_frame_done;
    assign err_pattern  = r_err_pattern;
    assign err_digit    = r_err_digit;
    assign display_lost = (r_to_cnt == TIMEOUT_MAX);

endmodule

// File: tb/tb_sev_seg_capture.sv
// ---------------------------------------------------------------------------
// tb_sev_seg_capture
//
// Scoreboard bench. Each stimulus segment (a pin pattern held for n cycles)
// updates a digit-level reference model and queues the expected output
// snapshot for the cycle it should appear; a monitor pops and compares on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_sev_seg_capture;

    localparam int SYNC = 2;
    localparam int STAB = 4;
    localparam int TO   = 50;
    localparam int LAT  = SYNC + STAB + 1;

    logic        clk;
    logic        rst;
    logic [7:0]  AN;
    logic [6:0]  Seg;
    logic        clear_err;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic [7:0]  seen;
    logic        frame_done;
    logic        err_pattern;
    logic [2:0]  err_digit;
    logic        display_lost;

    sev_seg_capture #(
        .SYNC_STAGES    (SYNC),
        .STABLE_CYCLES  (STAB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .AN           (AN),
        .Seg          (Seg),
        .clear_err    (clear_err),
        .digits       (digits),
        .blank        (blank),
        .seen         (seen),
        .frame_done   (frame_done),
        .err_pattern  (err_pattern),
        .err_digit    (err_digit),
        .display_lost (display_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
        end
    endtask

    // Active-high glyphs for 0..F.
    logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state
    logic [3:0]  m_dig [8];
    logic [7:0]  m_blk;
    logic [7:0]  m_seen;
    logic        m_err;
    logic [2:0]  m_errd;
    int          m_last;
    logic [14:0] m_pat;

    typedef struct {
        int          cyc;
        logic [31:0] dig;
        logic [7:0]  blk;
        logic [7:0]  seen;
        logic        frame;
        logic        err;
        logic [2:0]  errd;
        logic        lost;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_dig[k] = 4'h0;
        m_blk  = 8'hFF;
        m_seen = 8'h00;
        m_err  = 1'b0;
        m_errd = 3'd0;
        m_last = cyc;
        m_pat  = 15'h7FFF;
    endtask

    function automatic exp_t snap(input int c, input logic fr);
        exp_t e;
        e.cyc = c;
        for (int k = 0; k < 8; k++) e.dig[4*k +: 4] = m_dig[k];
        e.blk   = m_blk;
        e.seen  = m_seen;
        e.frame = fr;
        e.err   = m_err;
        e.errd  = m_errd;
        e.lost  = ((c - m_last) >= TO);
        return e;
    endfunction

    task automatic push(input exp_t e);
        int pos;
        pos = q.size();
        for (int k = 0; k < q.size(); k++) begin
            if (q[k].cyc > e.cyc) begin
                pos = k;
                break;
            end
        end
        q.insert(pos, e);
    endtask

    // Hold AN / active-high segment pattern for n cycles; clr_off>0 pulses
    // clear_err so that it is sampled on edge E+clr_off.
    task automatic seg(input logic [7:0] an, input logic [6:0] segon, input int n, input int clr_off);
        int          e_cyc;
        logic [14:0] p;
        logic [7:0]  sel;
        bit          cap;
        bit          found;
        bit          fr;
        int          idx;
        int          v;
        e_cyc = cyc;
        p     = {an, ~segon};
        sel   = ~an;
        cap   = (p != m_pat) && (n >= STAB + 1) && ($countones(sel) == 1);
        m_pat = p;
        if (clr_off > 0 && clr_off < LAT) m_err = 1'b0;
        if (cap) begin
            push(snap(e_cyc + LAT - 1, 1'b0));
            if (clr_off == LAT) m_err = 1'b0;
            idx = 0;
            for (int k = 0; k < 8; k++) if (sel[k]) idx = k;
            found = 0;
            v = 0;
            for (int k = 0; k < 16; k++) if (hex_tbl[k] == segon) begin found = 1; v = k; end
            if (found) begin
                m_dig[idx] = 4'(v);
                m_blk[idx] = 1'b0;
            end else if (segon == 7'h00) begin
                m_blk[idx] = 1'b1;
            end else begin
                if (!m_err) m_errd = 3'(idx);
                m_err = 1'b1;
            end
            m_seen[idx] = 1'b1;
            m_last = e_cyc + LAT;
            fr = (m_seen == 8'hFF);
            push(snap(e_cyc + LAT, fr));
            if (fr) begin
                m_seen = 8'h00;
                push(snap(e_cyc + LAT + 1, 1'b0));
            end
        end else if (n >= STAB + 1) begin
            if (clr_off == LAT) m_err = 1'b0;
            push(snap(e_cyc + LAT, 1'b0));
        end
        $display("seg cyc=%0d AN=%h seg_on=%h hold=%0d clr=%0d capture=%0d", e_cyc, an, segon, n, clr_off, cap);
        AN  = an;
        Seg = ~segon;
        for (int i = 0; i < n; i++) begin
            clear_err = (clr_off > 0) && (i == clr_off - 1);
            @(posedge clk);
            #1;
        end
        clear_err = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && q.size() > 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_digits"}, digits, 32'h0);
        chk({tag, "_blank"}, {24'h0, blank}, 32'hFF);
        chk({tag, "_seen"}, {24'h0, seen}, 32'h0);
        chk({tag, "_frame"}, {31'h0, frame_done}, 32'h0);
        chk({tag, "_err"}, {31'h0, err_pattern}, 32'h0);
        chk({tag, "_errd"}, {29'h0, err_digit}, 32'h0);
        chk({tag, "_lost"}, {31'h0, display_lost}, 32'h0);
    endtask

    // Monitor
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            if (mon_e.cyc != cyc) begin
                chk("stale_entry", 32'(cyc), 32'(mon_e.cyc));
            end else begin
                chk("digits", digits, mon_e.dig);
                chk("blank", {24'h0, blank}, {24'h0, mon_e.blk});
                chk("seen", {24'h0, seen}, {24'h0, mon_e.seen});
                chk("frame_done", {31'h0, frame_done}, {31'h0, mon_e.frame});
                chk("err_pattern", {31'h0, err_pattern}, {31'h0, mon_e.err});
                chk("err_digit", {29'h0, err_digit}, {29'h0, mon_e.errd});
                chk("display_lost", {31'h0, display_lost}, {31'h0, mon_e.lost});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] an_r;
        logic [6:0] sg_r;
        int         n_r;
        int         clr_r;
        int         kind;

        rst       = 1'b0;
        AN        = 8'hFF;
        Seg       = 7'h7F;
        clear_err = 1'b0;
        #1 rst = 1'b1;
        #1 chk_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Full scan 0..7 -> one frame, then re-hold digit 7 (same window).
        for (int v = 0; v < 8; v++) seg(~(8'h01 << v), hex_tbl[v], 10, 0);
        seg(8'h7F, hex_tbl[7], 10, 0);

        // Mid-window asynchronous reset.
        drain();
        AN  = 8'hFD;
        Seg = ~7'h06;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        AN  = 8'hFF;
        Seg = 7'h7F;
        #1 chk_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        seg(8'hFE, 7'h5B, 10, 0);

        // Ghost glyph for 3 cycles, then the real one.
        seg(8'hFD, 7'h06, 3, 0);
        seg(8'hFD, 7'h4F, 12, 0);

        // Errors and clear_err, including a clear coinciding with a bad capture.
        seg(8'hDF, 7'h01, 10, 0);
        seg(8'hFB, 7'h01, 10, 0);
        seg(8'hFB, hex_tbl[0], 10, 2);
        seg(8'hEF, 7'h01, 10, LAT);
        seg(8'hEF, hex_tbl[6], 10, 2);

        // Two anodes low: no capture.
        seg(8'hFC, hex_tbl[6], 20, 0);

        // Scan loss, then recovery.
        push(snap(m_last + TO - 1, 1'b0));
        push(snap(m_last + TO, 1'b0));
        seg(8'hFF, 7'h00, 60, 0);
        seg(8'h7F, hex_tbl[14], 10, 0);

        // Randomised segments.
        for (int t = 0; t < 40; t++) begin
            do begin
                kind = $urandom_range(0, 9);
                an_r = ~(8'h01 << $urandom_range(0, 7));
                sg_r = hex_tbl[$urandom_range(0, 15)];
                if (kind == 7) sg_r = 7'h00;
                if (kind == 8) begin
                    sg_r = 7'(~$urandom_range(1, 127));
                    while (sg_r == 7'h00 || sg_r inside {7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                           7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71})
                        sg_r = 7'($urandom_range(1, 127));
                end
                if (kind == 9) an_r = an_r & ~(8'h01 << $urandom_range(0, 7)) & 8'hF7 | 8'h00;
            end while ({an_r, ~sg_r} == m_pat);
            n_r   = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 4) : $urandom_range(5, 14);
            clr_r = 0;
            if (n_r >= LAT && $urandom_range(0, 9) == 0)
                clr_r = ($urandom_range(0, 1) == 0) ? 2 : LAT;
            seg(an_r, sg_r, n_r, clr_r);
        end

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
